mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 210 +++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit -- multi-cycle multiply/divide unit with HI/LO registers.
//
// An accepted start latches A, B and MDUop, holds busy high for MULT_CYCLES
// (mult/multu) or DIV_CYCLES (div/divu) cycles, then writes the result into
// HI/LO. For multiplies, HI:LO is the 64-bit product. For divides, LO is the
// quotient and HI is the remainder. mthi/mtlo write A into HI/LO when the unit
// is idle. MDUout is a combinational read mux over HI/LO.
//
// Optional feature: define MDU_DIV_ZERO_GUARD_EN to protect HI/LO on a divide
// by zero. With it defined, HI/LO are left unchanged and div_zero pulses for
// one cycle at completion. Without it, a divide by zero gives HI = A and
// LO = 0xFFFFFFFF, and the div_zero port does not exist.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  launch operation selected by MDUop
//   MDUop    in   3  000 mult, 001 multu, 010 div, 011 divu, others no-op
//   HIWrite  in   1  mthi: HI <= A
//   LOWrite  in   1  mtlo: LO <= A
//   HIRead   in   1  select HI onto MDUout
//   LORead   in   1  select LO onto MDUout
//   A, B     in  32  operands (rs, rt)
//   Req      in   1  flush of the current E-stage instruction
//   busy     out  1  operation in flight
//   MDUout   out 32  read data
//   div_zero out  1  (MDU_DIV_ZERO_GUARD_EN only) divide-by-zero completion pulse
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  MDUop,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        HIRead,
  input  logic        LORead,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  output logic        busy,
  output logic [31:0] MDUout
`ifdef MDU_DIV_ZERO_GUARD_EN
  ,
  output logic        div_zero
`endif
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               done;

  logic [31:0]        a_p0, b_p0;
  logic [2:0]         op_p0;
  logic [31:0]        hi_q, lo_q;

  logic [63:0]        prod;
  logic [63:0]        divres;
  logic [31:0]        res_hi, res_lo;
  logic               res_wr;
`ifdef MDU_DIV_ZERO_GUARD_EN
  logic               res_dz;
`endif

  // Low 64 bits of a product are the same whatever the operand signedness,
  // so only the extension differs between mult and multu.
  function automatic logic [63:0] mul_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    logic signed [63:0] p;
    ea = sgn ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
    p  = ea * eb;
    return p;
  endfunction

  // Signed divide on magnitudes. The quotient truncates toward zero, and the
  // remainder follows the dividend's sign. 0x80000000 / -1 wraps to
  // 0x80000000 with remainder 0. Returns {remainder, quotient}.
  function automatic logic [63:0] div_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic sgn);
    logic [31:0] ma, mb, q, r;
    logic        neg_q, neg_r;
    neg_r = sgn & a[31];
    neg_q = sgn & (a[31] ^ b[31]);
    ma    = neg_r ? -a : a;
    mb    = (sgn & b[31]) ? -b : b;
    q     = ma / mb;
    r     = ma % mb;
    q     = neg_q ? -q : q;
    r     = neg_r ? -r : r;
    return {r, q};
  endfunction

  // ---- Control: state and cycle counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !Req && !MDUop[2]) begin
          accept  = 1'b1;
          state_d = RUN;
          cnt_d   = MDUop[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      RUN: begin
        // The final busy cycle is the one with cnt_q == 1. Completing here
        // from RUN means the same edge can never also accept a new start.
        if (cnt_q <= CNT_W'(1)) begin
          done    = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---- Stage p0: operand latch on accept ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= A;
      b_p0  <= B;
      op_p0 <= MDUop;
    end
  end

  always_comb begin
    prod   = mul_fn(a_p0, b_p0, ~op_p0[0]);
    divres = div_fn(a_p0, b_p0, ~op_p0[0]);
    res_hi = '0;
    res_lo = '0;
    res_wr = 1'b0;
`ifdef MDU_DIV_ZERO_GUARD_EN
    res_dz = 1'b0;
`endif
    if (!op_p0[1]) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
      res_wr = 1'b1;
    end else if (b_p0 == 32'd0) begin
`ifdef MDU_DIV_ZERO_GUARD_EN
      res_dz = 1'b1;
`else
      res_hi = a_p0;
      res_lo = 32'hFFFF_FFFF;
      res_wr = 1'b1;
`endif
    end else begin
      res_hi = divres[63:32];
      res_lo = divres[31:0];
      res_wr = 1'b1;
    end
  end

  // ---- Stage p1: HI/LO architectural state ----
  // An accepted start takes priority: mthi/mtlo in the same cycle are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (done) begin
      if (res_wr) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else if (state_q == IDLE && !Req && !accept) begin
      if (HIWrite) hi_q <= A;
      if (LOWrite) lo_q <= A;
    end
  end

`ifdef MDU_DIV_ZERO_GUARD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_zero <= 1'b0;
    else        div_zero <= done & res_dz;
  end
`endif

  assign busy   = (state_q == RUN);
  assign MDUout = HIRead ? hi_q : (LORead ? lo_q : 32'd0);

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  MDUop;
  logic        HIWrite, LOWrite, HIRead, LORead;
  logic [31:0] A, B;
  logic        Req;
  logic        busy;
  logic [31:0] MDUout;
`ifdef MDU_DIV_ZERO_GUARD_EN
  logic        div_zero;
  int          dz_cnt = 0;
  always @(negedge clk) if (div_zero) dz_cnt++;
`endif

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .MDUop(MDUop),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .HIRead(HIRead), .LORead(LORead),
    .A(A), .B(B), .Req(Req), .busy(busy), .MDUout(MDUout)
`ifdef MDU_DIV_ZERO_GUARD_EN
    , .div_zero(div_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer arithmetic from the operation definitions.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    case (op)
      3'd0: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      3'd1: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
`ifndef MDU_DIV_ZERO_GUARD_EN
          m_hi = a; m_lo = 32'hFFFF_FFFF;
`endif
        end else begin
          if (op == 3'd2) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
          end else begin
            sa = longint'({32'b0, a}); sb = longint'({32'b0, b});
          end
          q = sa / sb;
          r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the first busy cycle.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDUop = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_hl(input string name);
    HIRead = 1'b1; LORead = 1'b0; #1;
    chk({name, "_hi"}, MDUout, m_hi);
    HIRead = 1'b0; LORead = 1'b1; #1;
    chk({name, "_lo"}, MDUout, m_lo);
    LORead = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    launch(op, a, b);
    wait_idle(n);
    chk({name, "_cycles"}, n, op[1] ? DC : MC);
  endtask

  vec_t vecs[8];

  initial begin
    int n;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{3'd3, 32'd7,         32'd2,        32'd1,         32'd3};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[5] = '{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[6] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[7] = '{3'd1, 32'h8000_0000, 32'd2,        32'd1,         32'h0};

    rst_n = 1'b0; start = 1'b0; MDUop = '0; HIWrite = 1'b0; LOWrite = 1'b0;
    HIRead = 1'b0; LORead = 1'b0; A = '0; B = '0; Req = 1'b0;
    m_hi = '0; m_lo = '0;
    #12;
    chk("reset_busy", {31'b0, busy}, 32'd0);
    check_hl("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of directed vectors with fixed expected results.
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
      m_hi = vecs[i].hi; m_lo = vecs[i].lo;
      check_hl($sformatf("vec%0d", i));
      @(negedge clk);
    end

    // multu with mthi (and a Req flush) during RUN: both ignored, op completes.
    launch(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    HIWrite = 1'b1; A = 32'h1234;
    @(negedge clk);
    HIWrite = 1'b0; Req = 1'b1;
    @(negedge clk);
    Req = 1'b0;
    wait_idle(n);
    chk("mthi_run_cycles", n + 2, MC);
    m_hi = 32'hFFFF_FFFE; m_lo = 32'h0000_0001;
    check_hl("mthi_run");
    @(negedge clk);

    // start beats mthi/mtlo in the same cycle; HI read while busy shows old HI.
    MDUop = 3'd0; A = 32'd3; B = 32'd4; start = 1'b1; HIWrite = 1'b1; LOWrite = 1'b1;
    @(negedge clk);
    start = 1'b0; HIWrite = 1'b0; LOWrite = 1'b0;
    check_hl("prio_busy");
    wait_idle(n);
    m_hi = 32'd0; m_lo = 32'd12;
    check_hl("prio_done");
    @(negedge clk);

    // start and mthi with Req=1 are ignored; then mtlo with Req=0 lands.
    MDUop = 3'd0; A = 32'd2; B = 32'd2; start = 1'b1; Req = 1'b1; HIWrite = 1'b1;
    @(negedge clk);
    start = 1'b0; Req = 1'b0; HIWrite = 1'b0;
    chk("req_busy", {31'b0, busy}, 32'd0);
    check_hl("req_nochange");
    @(negedge clk);
    LOWrite = 1'b1; A = 32'hABCD;
    @(negedge clk);
    LOWrite = 1'b0;
    m_lo = 32'hABCD;
    check_hl("mtlo");
    @(negedge clk);

    // Reset three cycles into a divide: immediate clear, no later write.
    launch(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_run_busy", {31'b0, busy}, 32'd0);
    m_hi = '0; m_lo = '0;
    check_hl("rst_run");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("rst_after_busy", {31'b0, busy}, 32'd0);
    check_hl("rst_after");

    // Divide by zero following a known nonzero HI/LO.
    run_op("pre_dz", 3'd1, 32'hFFFF_FFFF, 32'd3);
    model(3'd1, 32'hFFFF_FFFF, 32'd3);
    check_hl("pre_dz");
    @(negedge clk);
`ifdef MDU_DIV_ZERO_GUARD_EN
    n = dz_cnt;
`endif
    run_op("dz", 3'd3, 32'd9, 32'd0);
    repeat (2) @(negedge clk);
`ifdef MDU_DIV_ZERO_GUARD_EN
    chk("dz_pulses", dz_cnt - n, 32'd1);
`else
    m_hi = 32'd9; m_lo = 32'hFFFF_FFFF;
`endif
    check_hl("dz");

    // Randomized operations against the arithmetic reference.
    for (int k = 0; k < 24; k++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (k % 4 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run_op($sformatf("rnd%0d", k), rop, ra, rb);
      model(rop, ra, rb);
      check_hl($sformatf("rnd%0d", k));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
